// File: rtl/bus_arb_pkg.sv
// Shared encodings and arbitration helper for the instruction/data bus arbiter.
package bus_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Preferred requester wins a tie unless it also won the previous grant.
    function automatic logic arb_pick(input logic ireq, input logic dreq,
                                      input logic d_first, input logic last);
        logic prefer;
        prefer = d_first ? OWN_D : OWN_I;
        if (ireq && dreq)
            return (last == prefer) ? ~prefer : prefer;
        return dreq ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter onto a single split
// address/data memory port with one outstanding transaction.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter logic D_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_stall,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_stall,

    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_sel,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic        owner_reg;
    logic        last_reg;
    mem_req_t    req_reg;
    logic [31:0] i_rdata_reg;
    logic [31:0] d_rdata_reg;

    logic        grant;
    logic        grant_owner;
    mem_req_t    grant_req;
    logic        complete;
    logic        i_done;
    logic        d_done;

    always_comb begin
        grant       = (state_reg == ST_IDLE) && (i_req || d_req);
        grant_owner = arb_pick(i_req, d_req, D_FIRST, last_reg);
        if (grant_owner == OWN_D) begin
            grant_req.wr    = d_wr;
            grant_req.sel   = d_sel;
            grant_req.addr  = d_addr;
            grant_req.wdata = d_wdata;
        end else begin
            grant_req.wr    = 1'b0;
            grant_req.sel   = 4'hF;
            grant_req.addr  = i_addr;
            grant_req.wdata = 32'd0;
        end
    end

    // Handshakes are only honoured in the phase that expects them.
    assign complete = (state_reg == ST_DATA) && m_data_ok;
    assign i_done   = complete && (owner_reg == OWN_I);
    assign d_done   = complete && (owner_reg == OWN_D);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant)     state_next = ST_ADDR;
            ST_ADDR: if (m_addr_ok) state_next = ST_DATA;
            ST_DATA: if (m_data_ok) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_I;
            last_reg  <= OWN_I;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                owner_reg <= grant_owner;
                last_reg  <= grant_owner;
            end
        end
    end

    // Request and read-data holding registers: enabled flops with reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_reg     <= '0;
            i_rdata_reg <= 32'd0;
            d_rdata_reg <= 32'd0;
        end else begin
            if (grant)
                req_reg <= grant_req;
            if (i_done)
                i_rdata_reg <= m_rdata;
            if (d_done)
                d_rdata_reg <= m_rdata;
        end
    end

    assign m_req   = (state_reg == ST_ADDR);
    assign m_wr    = req_reg.wr;
    assign m_sel   = req_reg.sel;
    assign m_addr  = req_reg.addr;
    assign m_wdata = req_reg.wdata;

    assign i_stall = i_req && !i_done;
    assign d_stall = d_req && !d_done;
    assign i_rdata = i_done ? m_rdata : i_rdata_reg;
    assign d_rdata = d_done ? m_rdata : d_rdata_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench: requesters and memory are driven with $urandom and every
// output is compared each cycle against a transaction-level reference model.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_sel;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;
    int txns   = 0;

    bus_arbiter #(.D_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_sel(d_sel), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_req(m_req), .m_wr(m_wr), .m_sel(m_sel), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one in-flight transaction described by flags and fields.
    bit          busy, accepted, own_d, last_d;
    bit          t_wr;
    bit [3:0]    t_sel;
    bit [31:0]   t_addr, t_wdata, i_data, d_data;
    bit          i_pend, d_pend;

    task automatic model_reset();
        busy = 0; accepted = 0; own_d = 0; last_d = 0;
        t_wr = 0; t_sel = 0; t_addr = 0; t_wdata = 0;
        i_data = 0; d_data = 0;
    endtask

    task automatic check_outputs();
        bit done, i_fin, d_fin;
        done  = busy && accepted && m_data_ok;
        i_fin = done && !own_d;
        d_fin = done && own_d;
        check_val("m_req",   32'(m_req), 32'(busy && !accepted));
        check_val("m_wr",    32'(m_wr), 32'(t_wr));
        check_val("m_sel",   32'(m_sel), 32'(t_sel));
        check_val("m_addr",  m_addr, t_addr);
        check_val("m_wdata", m_wdata, t_wdata);
        check_val("i_stall", 32'(i_stall), 32'(i_req && !i_fin));
        check_val("d_stall", 32'(d_stall), 32'(d_req && !d_fin));
        check_val("i_rdata", i_rdata, i_fin ? m_rdata : i_data);
        check_val("d_rdata", d_rdata, d_fin ? m_rdata : d_data);
    endtask

    task automatic model_step();
        bit win_d;
        if (!busy) begin
            if (i_req || d_req) begin
                // Data wins ties by default; the two alternate under contention.
                win_d = d_req && (!i_req || !last_d);
                busy = 1; accepted = 0; own_d = win_d; last_d = win_d;
                if (win_d) begin
                    t_wr = d_wr; t_sel = d_sel; t_addr = d_addr; t_wdata = d_wdata;
                end else begin
                    t_wr = 0; t_sel = 4'hF; t_addr = i_addr; t_wdata = 0;
                end
            end
        end else if (!accepted) begin
            if (m_addr_ok) accepted = 1;
        end else if (m_data_ok) begin
            busy = 0;
            txns++;
            $display("txn %0d: %s addr=%h wr=%0d sel=%h wdata=%h rdata=%h",
                     txns, own_d ? "D" : "I", t_addr, t_wr, t_sel, t_wdata, m_rdata);
            if (own_d) begin
                d_data = m_rdata; d_pend = 0;
            end else begin
                i_data = m_rdata; i_pend = 0;
            end
        end
    endtask

    initial begin
        rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_sel = 0;
        d_addr = 0; d_wdata = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        i_pend = 0; d_pend = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 0;

        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_wr = 1'($urandom); d_sel = 4'($urandom);
                d_addr = $urandom; d_wdata = $urandom;
            end
            // Occasionally abandon a request after it has been granted.
            if (i_pend && busy && !own_d && $urandom_range(0, 9) == 0) i_pend = 0;
            if (d_pend && busy && own_d && $urandom_range(0, 9) == 0) d_pend = 0;
            i_req = i_pend;
            d_req = d_pend;
            m_addr_ok = 1'($urandom);
            m_data_ok = 1'($urandom);
            m_rdata   = $urandom;
            #1;
            if (rst) model_reset();
            check_outputs();
            if (!rst) model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter D_FIRST, default 1, meaning: 1 = data requester wins simultaneous requests in IDLE, 0 = instruction requester wins.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req  in  1  instruction fetch request; i_addr  in  32  fetch address.
REQ-005 i_rdata  out  32  fetch data; i_stall  out  1  fetch not yet complete.
REQ-006 d_req  in  1  load/store request; d_wr  in  1  1=store; d_sel  in  4  byte enables; d_addr  in  32; d_wdata  in  32.
REQ-007 d_rdata  out  32  load data; d_stall  out  1  data access not yet complete.
REQ-008 m_req  out  1; m_wr  out  1; m_sel  out  4; m_addr  out  32; m_wdata  out  32  shared memory request port.
REQ-009 m_addr_ok  in  1  address accepted; m_data_ok  in  1  response valid; m_rdata  in  32  response data.

Function
REQ-010 FSM states IDLE, ADDR, DATA; a 1-bit owner register (I or D) and a 1-bit last-grant register.
REQ-011 IDLE: with both requests pending, grant D if D_FIRST=1, except grant I when last grant was D; grant the only pending requester otherwise; go to ADDR on a grant.
REQ-012 On a grant, latch owner's addr, wr, sel, wdata (I: wr=0, sel=4'hF, wdata=0) into request registers; m_* outputs come only from these registers.
REQ-013 ADDR: m_req=1; outputs stable until m_addr_ok; m_addr_ok=1 -> DATA.
REQ-014 DATA: m_req=0; m_data_ok=1 -> IDLE and capture m_rdata into owner's rdata register.
REQ-015 m_data_ok outside DATA and m_addr_ok outside ADDR are ignored.
REQ-016 x_stall = x_req AND NOT (state=DATA AND owner=x AND m_data_ok); combinational.
REQ-017 x_rdata = m_rdata in the completing cycle, otherwise the last captured value for that requester.
REQ-018 Minimum latency: request in IDLE cycle 0, m_req cycle 1, completion (stall low) cycle 2 with same-cycle addr_ok/data_ok.
REQ-019 A requester dropping x_req after grant does not abort; transaction completes, data captured, no stall generated.
REQ-020 A requester holding x_req after completion is re-arbitrated as a new request in the next IDLE.
REQ-021 Non-owner stall stays high during the owner's entire transaction.

Reset
REQ-022 rst asserted at any time: state=IDLE, m_req=0, m_wr=0, m_sel=0, m_addr=0, m_wdata=0, both rdata registers=0, last grant=I, owner=I, immediately and asynchronously.
REQ-023 A response arriving after reset mid-transaction is ignored per REQ-015.
REQ-024 Stall outputs remain combinational during reset: x_stall = x_req.

Structure
REQ-025 Shared package bus_arb_pkg holds the state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and owner encoding (I=0, D=1).
REQ-026 Single module; no sub-module; request registers use the codebase's enabled reset flop.

Verification
REQ-027 I only: i_req=1, i_addr=0xBFC00000, memory addr_ok/data_ok immediate, rdata=0x24080001 -> m_req cycle 1, i_stall low and i_rdata=0x24080001 cycle 2.
REQ-028 Simultaneous: i_req=d_req=1, D_FIRST=1, store d_addr=0x100, d_sel=4'b0011, d_wdata=0xAABBCCDD -> D served first (m_wr=1, m_sel=4'b0011), then I; i_stall high throughout D.
REQ-029 Fairness: d_req held high with i_req high for 4 transactions -> grants alternate D,I,D,I.
REQ-030 Backpressure: m_addr_ok low 3 cycles -> m_req and m_addr stable all 3 cycles; m_data_ok delayed 2 cycles -> stall held, completion on the data_ok cycle.
REQ-031 Reset in DATA: assert rst while awaiting m_data_ok, deassert, then pulse m_data_ok -> no capture, state IDLE, rdata=0.
REQ-032 Abort: d_req dropped in ADDR -> transaction completes, d_rdata updated, d_stall low.
